// File: rtl/axi_crc_pkg.sv
// rtl/axi_crc_pkg.sv - shared constants and channel state types for the AXI-Lite CRC-32 block
package axi_crc_pkg;

  localparam int unsigned OFF_SEED   = 32'h00;
  localparam int unsigned OFF_DATA   = 32'h04;
  localparam int unsigned OFF_RESULT = 32'h08;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DATA} rd_state_e;

endpackage

// File: rtl/crc32_word.sv
// rtl/crc32_word.sv - combinational CRC-32 advance over one 32-bit word, LSB first
module crc32_word
  import axi_crc_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_out
);

  // Reflected form: bit 0 of the word enters first, so byte [7:0] is processed first.
  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 32; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY_REFL;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/axi_crc_top.sv
// rtl/axi_crc_top.sv - AXI-Lite slave exposing seed/data/result registers of a CRC-32 engine
module axi_crc_top
  import axi_crc_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [1:0]            s_bresp,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp
);

  wr_state_e   w_state;
  rd_state_e   r_state;
  logic [31:0] crc_state;
  logic [31:0] seed_q;
  logic [31:0] data_q;
  logic [31:0] crc_next;

  crc32_word u_crc32_word (
    .crc_in (crc_state),
    .data   (s_wdata[31:0]),
    .crc_out(crc_next)
  );

  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      w_state   <= W_IDLE;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      crc_state <= CRC32_INIT;
      seed_q    <= CRC32_INIT;
      data_q    <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_awvalid && s_wvalid) begin
            w_state   <= W_ACCEPT;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
          end
        end
        W_ACCEPT: begin
          s_awready <= 1'b0;
          s_wready  <= 1'b0;
          // A master that dropped either valid during the ready cycle gets nothing committed.
          if (s_awvalid && s_wvalid) begin
            w_state  <= W_RESP;
            s_bvalid <= 1'b1;
            s_bresp  <= RESP_OKAY;
            if (s_awaddr == ADDR_WIDTH'(OFF_SEED)) begin
              seed_q    <= s_wdata[31:0];
              crc_state <= s_wdata[31:0];
            end else if (s_awaddr == ADDR_WIDTH'(OFF_DATA)) begin
              data_q    <= s_wdata[31:0];
              crc_state <= crc_next;
            end else begin
              s_bresp <= RESP_SLVERR;
            end
          end else begin
            w_state <= W_IDLE;
          end
        end
        W_RESP: begin
          if (s_bready) begin
            w_state  <= W_IDLE;
            s_bvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_arvalid) begin
            r_state   <= R_ACCEPT;
            s_arready <= 1'b1;
          end
        end
        R_ACCEPT: begin
          s_arready <= 1'b0;
          if (s_arvalid) begin
            r_state  <= R_DATA;
            s_rvalid <= 1'b1;
            s_rresp  <= RESP_OKAY;
            if (s_araddr == ADDR_WIDTH'(OFF_SEED))        s_rdata <= DATA_WIDTH'(seed_q);
            else if (s_araddr == ADDR_WIDTH'(OFF_DATA))   s_rdata <= DATA_WIDTH'(data_q);
            else if (s_araddr == ADDR_WIDTH'(OFF_RESULT)) s_rdata <= DATA_WIDTH'(~crc_state);
            else begin
              s_rdata <= '0;
              s_rresp <= RESP_SLVERR;
            end
          end else begin
            r_state <= R_IDLE;
          end
        end
        R_DATA: begin
          if (s_rready) begin
            r_state  <= R_IDLE;
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_crc_top.sv
// tb/tb_axi_crc_top.sv - randomized self-checking bench for axi_crc_top against a table-driven CRC model
module tb_axi_crc_top;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b1;
  logic        s_awvalid = 1'b0, s_awready;
  logic [7:0]  s_awaddr = '0;
  logic        s_wvalid = 1'b0, s_wready;
  logic [31:0] s_wdata = '0;
  logic        s_bvalid, s_bready = 1'b0;
  logic [1:0]  s_bresp;
  logic        s_arvalid = 1'b0, s_arready;
  logic [7:0]  s_araddr = '0;
  logic        s_rvalid, s_rready = 1'b0;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;

  int n_compared = 0;
  int n_mismatch = 0;

  logic [31:0] crc_tab [256];
  logic [31:0] m_seed;
  byte unsigned m_msg [$];

  always #5 ACLK = ~ACLK;

  axi_crc_top #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Byte-at-a-time table CRC over the whole message since the last seed, then final XOR.
  function automatic logic [31:0] model_result();
    logic [31:0] c;
    c = m_seed;
    foreach (m_msg[i]) c = crc_tab[(c ^ 32'(m_msg[i])) & 32'hFF] ^ (c >> 8);
    return ~c;
  endfunction

  function automatic void model_seed(input logic [31:0] s);
    m_seed = s;
    m_msg.delete();
  endfunction

  function automatic void model_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) m_msg.push_back(8'((w >> (8 * b)) & 32'hFF));
  endfunction

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input int stall,
                           output logic [1:0] resp);
    @(posedge ACLK); #1;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_awaddr = addr; s_wdata = data;
    @(posedge ACLK); #1;
    check_eq("awready", 32'(s_awready), 32'd1);
    check_eq("wready", 32'(s_wready), 32'd1);
    @(posedge ACLK); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check_eq("bvalid_lat", 32'(s_bvalid), 32'd1);
    resp = s_bresp;
    for (int i = 0; i < stall; i++) begin
      @(posedge ACLK); #1;
      check_eq("bvalid_hold", 32'(s_bvalid), 32'd1);
      check_eq("bresp_hold", 32'(s_bresp), 32'(resp));
    end
    s_bready = 1'b1;
    @(posedge ACLK); #1;
    s_bready = 1'b0;
    check_eq("bvalid_clr", 32'(s_bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [7:0] addr, input int stall,
                          output logic [31:0] data, output logic [1:0] resp);
    @(posedge ACLK); #1;
    s_arvalid = 1'b1; s_araddr = addr;
    @(posedge ACLK); #1;
    check_eq("arready", 32'(s_arready), 32'd1);
    @(posedge ACLK); #1;
    s_arvalid = 1'b0;
    check_eq("rvalid_lat", 32'(s_rvalid), 32'd1);
    data = s_rdata;
    resp = s_rresp;
    for (int i = 0; i < stall; i++) begin
      @(posedge ACLK); #1;
      check_eq("rvalid_hold", 32'(s_rvalid), 32'd1);
      check_eq("rdata_hold", s_rdata, data);
      check_eq("rresp_hold", 32'(s_rresp), 32'(resp));
    end
    s_rready = 1'b1;
    @(posedge ACLK); #1;
    s_rready = 1'b0;
    check_eq("rvalid_clr", 32'(s_rvalid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, first, w, sd;
    logic [1:0]  rs, bs;

    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end
    model_seed(32'hFFFFFFFF);

    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1'b0;
    check_eq("rst_awready", 32'(s_awready), 32'd0);
    check_eq("rst_wready", 32'(s_wready), 32'd0);
    check_eq("rst_bvalid", 32'(s_bvalid), 32'd0);
    check_eq("rst_bresp", 32'(s_bresp), 32'd0);
    check_eq("rst_arready", 32'(s_arready), 32'd0);
    check_eq("rst_rvalid", 32'(s_rvalid), 32'd0);
    check_eq("rst_rdata", s_rdata, 32'd0);
    check_eq("rst_rresp", 32'(s_rresp), 32'd0);

    axi_read(8'h08, 0, rd, rs);
    check_eq("rst_result", rd, 32'h00000000);
    check_eq("rst_result_resp", 32'(rs), 32'd0);
    axi_read(8'h00, 0, rd, rs);
    check_eq("rst_seed", rd, 32'hFFFFFFFF);
    axi_read(8'h04, 0, rd, rs);
    check_eq("rst_data", rd, 32'h00000000);

    axi_write(8'h00, 32'hFFFFFFFF, 0, bs); model_seed(32'hFFFFFFFF);
    check_eq("seed_bresp", 32'(bs), 32'd0);
    axi_write(8'h04, 32'h00000000, 0, bs); model_word(32'h00000000);
    check_eq("data_bresp", 32'(bs), 32'd0);
    axi_read(8'h08, 0, rd, rs);
    check_eq("crc_zero_word", rd, 32'h2144DF1C);
    check_eq("crc_zero_model", rd, model_result());
    check_eq("crc_zero_resp", 32'(rs), 32'd0);
    axi_read(8'h04, 0, rd, rs);
    check_eq("data_echo_zero", rd, 32'h00000000);

    axi_write(8'h00, 32'hFFFFFFFF, 0, bs); model_seed(32'hFFFFFFFF);
    axi_write(8'h04, 32'h64636261, 0, bs); model_word(32'h64636261);
    axi_read(8'h08, 0, rd, rs);
    check_eq("crc_abcd", rd, 32'hED82CD11);
    first = rd;
    axi_write(8'h04, 32'h00000000, 0, bs); model_word(32'h00000000);
    axi_read(8'h08, 0, rd, rs);
    check_eq("crc_abcd_zero4", rd, model_result());
    axi_write(8'h00, 32'hFFFFFFFF, 0, bs); model_seed(32'hFFFFFFFF);
    axi_write(8'h04, 32'h64636261, 0, bs); model_word(32'h64636261);
    axi_read(8'h08, 0, rd, rs);
    check_eq("crc_reseed_repeat", rd, first);

    axi_read(8'h0C, 0, rd, rs);
    check_eq("unmapped_rdata", rd, 32'd0);
    check_eq("unmapped_rresp", 32'(rs), 32'd2);
    axi_read(8'h01, 0, rd, rs);
    check_eq("unaligned_rresp", 32'(rs), 32'd2);
    axi_write(8'h08, 32'h12345678, 0, bs);
    check_eq("ro_bresp", 32'(bs), 32'd2);
    axi_read(8'h08, 0, rd, rs);
    check_eq("ro_unchanged", rd, model_result());
    axi_write(8'h0C, 32'hDEADBEEF, 0, bs);
    check_eq("unmapped_bresp", 32'(bs), 32'd2);
    axi_read(8'h08, 0, rd, rs);
    check_eq("unmapped_unchanged", rd, model_result());

    for (int n = 0; n < 5; n++) begin
      sd = $urandom();
      w  = $urandom();
      axi_write(8'h00, sd, (n == 1) ? 3 : 0, bs); model_seed(sd);
      axi_write(8'h04, w, (n == 2) ? 3 : 0, bs); model_word(w);
      axi_read(8'h04, (n == 3) ? 3 : 0, rd, rs);
      check_eq("rand_data_echo", rd, w);
      axi_read(8'h08, (n == 4) ? 3 : 0, rd, rs);
      check_eq("rand_crc", rd, model_result());
    end

    // Read of the result captured on the same edge as a data write commits sees the old CRC.
    first = model_result();
    w = $urandom();
    fork
      axi_write(8'h04, w, 0, bs);
      axi_read(8'h08, 0, rd, rs);
    join
    model_word(w);
    check_eq("overlap_pre_write", rd, first);
    axi_read(8'h08, 0, rd, rs);
    check_eq("overlap_post_write", rd, model_result());

    @(posedge ACLK); #1;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_awaddr = 8'h00; s_wdata = 32'h12345678;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; ARESETn = 1'b0;
    check_eq("midrst_bvalid", 32'(s_bvalid), 32'd0);
    check_eq("midrst_awready", 32'(s_awready), 32'd0);
    repeat (2) @(posedge ACLK);
    #1 check_eq("midrst_no_resp", 32'(s_bvalid), 32'd0);
    axi_read(8'h00, 0, rd, rs);
    check_eq("midrst_seed", rd, 32'hFFFFFFFF);
    axi_read(8'h08, 0, rd, rs);
    check_eq("midrst_result", rd, 32'h00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
